// File: rtl/delay_pipe_hs_pkg.sv
// Shared types and helpers for the handshaked delay pipe: ctrl bundle,
// depth sanity check and count-width function.
package delay_pipe_hs_pkg;

  typedef struct packed {
    logic clk;
    logic reset;
  } ctrl_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit depth_ok(input int depth);
    return depth >= 1;
  endfunction

endpackage

// File: rtl/delay_pipe_stage.sv
// One stage of the elastic delay line: a valid bit plus a data word,
// loading from the stage behind it whenever the parent says it advances.
module delay_pipe_stage
  import delay_pipe_hs_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             adv,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Flush only drops the valid bit; the data word is left as-is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= RESET;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= prev_valid;
      data  <= prev_data;
    end
  end

endmodule

// File: rtl/delay_pipe_hs.sv
// Elastic valid/ready delay line of DEPTH stages with bubble collapse and flush.
// Build option: DELAY_PIPE_ZERO_EN forces out_data to RESET while out_valid is low.
module delay_pipe_hs
  import delay_pipe_hs_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 3,
  parameter logic [WIDTH-1:0] RESET = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("delay_pipe_hs: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0][WIDTH-1:0] dat;
  logic [CW-1:0]               cnt;
  logic                        in_xfer, out_xfer;

  // A stage moves if it is empty or the stage ahead of it moves, so an
  // empty slot anywhere lets everything behind it close up.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = ~vld_pipe[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--)
      adv[i] = ~vld_pipe[i] | adv[i+1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             pv;
    logic [WIDTH-1:0] pd;
    if (i == 0) begin : g_head
      assign pv = in_valid;
      assign pd = in_data;
    end else begin : g_body
      assign pv = vld_pipe[i-1];
      assign pd = dat[i-1];
    end

    delay_pipe_stage #(.WIDTH(WIDTH), .RESET(RESET)) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .adv        (adv[i]),
      .prev_valid (pv),
      .prev_data  (pd),
      .valid      (vld_pipe[i]),
      .data       (dat[i])
    );
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = vld_pipe[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

`ifdef DELAY_PIPE_ZERO_EN
  assign out_data = out_valid ? dat[DEPTH-1] : RESET;
`else
  assign out_data = dat[DEPTH-1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (flush) cnt <= '0;
    else            cnt <= cnt + CW'(in_xfer) - CW'(out_xfer);
  end

  assign count = cnt;

endmodule

// File: tb/tb_delay_pipe_hs.sv
// Randomized scoreboard bench for delay_pipe_hs against a word-list model.
module tb_delay_pipe_hs;
  localparam int          D   = 3;
  localparam int          W   = 32;
  localparam logic [31:0] RST = 32'h5A5A;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [1:0]    count;

  int checks = 0;
  int errors = 0;

  // Model: accepted words in order, each with its current stage position.
  logic [31:0] wq[$];
  int          pq[$];
  bit          m_ir, m_ret;
  int          lim;

  logic        stale_chk = 1'b0;
  logic [31:0] stale_exp = '0;

  delay_pipe_hs #(.WIDTH(W), .DEPTH(D), .RESET(RST)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      wq.delete();
      pq.delete();
    end else begin
      m_ir  = !flush && (pq.size() < D || out_ready);
      m_ret = pq.size() > 0 && pq[0] == D - 1 && out_ready;
      if (m_ret) begin
        void'(wq.pop_front());
        void'(pq.pop_front());
      end
      if (flush) begin
        wq.delete();
        pq.delete();
      end else begin
        // Each word steps forward one slot unless the word ahead blocks it.
        for (int j = 0; j < pq.size(); j++) begin
          lim = (j == 0) ? D - 1 : pq[j-1] - 1;
          pq[j] = (pq[j] + 1 < lim) ? pq[j] + 1 : lim;
        end
        if (in_valid && m_ir) begin
          wq.push_back(in_data);
          pq.push_back(0);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_count", {30'd0, count}, 32'd0);
      chk("rst_out_data", out_data, RST);
    end else begin
      chk("in_ready", {31'd0, in_ready},
          {31'd0, (!flush && (pq.size() < D || out_ready))});
      chk("count", {30'd0, count}, pq.size());
      chk("out_valid", {31'd0, out_valid},
          {31'd0, (pq.size() > 0 && pq[0] == D - 1)});
      if (out_valid && pq.size() > 0 && pq[0] == D - 1)
        chk("out_data", out_data, wq[0]);
`ifdef DELAY_PIPE_ZERO_EN
      if (!out_valid) chk("zero_data", out_data, RST);
`else
      if (!out_valid && stale_chk) chk("stale_data", out_data, stale_exp);
`endif
    end
  end

  task automatic step(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step(0, 0, 1, 0);

    // streaming, then idle with in_data parked so the stale word is known
    step(1, 32'h11, 1, 0);
    step(1, 32'h22, 1, 0);
    step(1, 32'h33, 1, 0);
    repeat (4) step(0, 32'h33, 1, 0);
    stale_exp = 32'h33;
    stale_chk = 1'b1;
    repeat (3) step(0, 32'h33, 1, 0);
    stale_chk = 1'b0;

    // backpressure until full, then drain
    step(1, 32'hA1, 0, 0);
    step(1, 32'hA2, 0, 0);
    step(1, 32'hA3, 0, 0);
    step(1, 32'hA4, 0, 0);
    step(0, 32'hA4, 0, 0);
    repeat (5) step(0, 32'hA4, 1, 0);

    // bubble collapse
    step(1, 32'h0A, 0, 0);
    step(0, 32'h0A, 0, 0);
    step(1, 32'h0B, 0, 0);
    repeat (3) step(0, 32'h0B, 0, 0);
    repeat (4) step(0, 32'h0B, 1, 0);

    // flush with a word offered in the same cycle
    step(1, 32'h01, 0, 0);
    step(1, 32'h02, 0, 0);
    step(1, 32'hFF, 0, 1);
    repeat (4) step(0, 32'h00, 1, 0);

    // random traffic
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 3);

    // asynchronous reset mid-stream, checked before any further edge
    step(1, 32'hC1, 0, 0);
    step(1, 32'hC2, 0, 0);
    #3 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    step(1, 32'hD1, 1, 0);
    repeat (5) step(0, 32'hD1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
